// File: rtl/regfile_mp_if.sv
// Bundle of write, read and scoreboard-set signals for regfile_mp.
// The master side is issue/writeback; the slave side is the register file.
interface regfile_mp_if #(
   parameter int width_p    = 32,
   parameter int els_p      = 32,
   parameter int rd_ports_p = 2,
   parameter int wr_ports_p = 2
);
   localparam int lg_els = $clog2(els_p);

   logic [wr_ports_p-1:0]             wr_v_i;
   logic [wr_ports_p-1:0][lg_els-1:0] wr_addr_i;
   logic [wr_ports_p-1:0][width_p-1:0] wr_data_i;
   logic [rd_ports_p-1:0][lg_els-1:0] rd_addr_i;
   logic [rd_ports_p-1:0][width_p-1:0] rd_data_o;
   logic [rd_ports_p-1:0]             rd_pending_o;
   logic                              sb_set_v_i;
   logic [lg_els-1:0]                 sb_set_addr_i;

   modport master (
      output wr_v_i, wr_addr_i, wr_data_i,
      output rd_addr_i, sb_set_v_i, sb_set_addr_i,
      input  rd_data_o, rd_pending_o
   );

   modport slave (
      input  wr_v_i, wr_addr_i, wr_data_i,
      input  rd_addr_i, sb_set_v_i, sb_set_addr_i,
      output rd_data_o, rd_pending_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with optional bypass, hard-wired zero
// register and a per-register pending bit for RAW hazard detection.
module regfile_mp #(
   parameter int width_p    = 32,
   parameter int els_p      = 32,
   parameter int rd_ports_p = 2,
   parameter int wr_ports_p = 2,
   parameter int bypass_p   = 1,
   parameter int zero_reg_p = 1
) (
   input logic         clk_i,
   input logic         rst_i,
   regfile_mp_if.slave rf
);
   localparam int lg_els = $clog2(els_p);

   logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
   logic [els_p-1:0]              pend_q, pend_d;

   logic [rd_ports_p-1:0][width_p-1:0] rd_data;
   logic [rd_ports_p-1:0]              rd_pend;

   // Ascending port order lets the highest-indexed port win collisions;
   // the set is applied after the clears so a new producer wins.
   always_comb begin
      mem_d  = mem_q;
      pend_d = pend_q;
      for (int k = 0; k < wr_ports_p; k++) begin
         if (rf.wr_v_i[k]) begin
            mem_d[rf.wr_addr_i[k]]  = rf.wr_data_i[k];
            pend_d[rf.wr_addr_i[k]] = 1'b0;
         end
      end
      if (rf.sb_set_v_i) begin
         pend_d[rf.sb_set_addr_i] = 1'b1;
      end
      if (zero_reg_p != 0) begin
         mem_d[0]  = '0;
         pend_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q  <= '0;
         pend_q <= '0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_pend = '0;
      for (int j = 0; j < rd_ports_p; j++) begin
         logic hit;
         hit        = 1'b0;
         rd_data[j] = mem_q[rf.rd_addr_i[j]];
         for (int k = 0; k < wr_ports_p; k++) begin
            if (bypass_p != 0 && rf.wr_v_i[k] &&
                rf.wr_addr_i[k] == rf.rd_addr_i[j]) begin
               rd_data[j] = rf.wr_data_i[k];
               hit        = 1'b1;
            end
         end
         rd_pend[j] = pend_q[rf.rd_addr_i[j]] & ~hit;
         if (zero_reg_p != 0 && rf.rd_addr_i[j] == lg_els'(0)) begin
            rd_data[j] = '0;
            rd_pend[j] = 1'b0;
         end
      end
   end

   assign rf.rd_data_o    = rd_data;
   assign rf.rd_pending_o = rd_pend;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp with a bypass instance
// and a no-bypass instance sharing the same stimulus.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   regfile_mp_if bif ();
   regfile_mp_if nif ();

   assign nif.wr_v_i        = bif.wr_v_i;
   assign nif.wr_addr_i     = bif.wr_addr_i;
   assign nif.wr_data_i     = bif.wr_data_i;
   assign nif.rd_addr_i     = bif.rd_addr_i;
   assign nif.sb_set_v_i    = bif.sb_set_v_i;
   assign nif.sb_set_addr_i = bif.sb_set_addr_i;

   regfile_mp #(.bypass_p(1)) u_byp (
      .clk_i(clk), .rst_i(rst), .rf(bif)
   );

   regfile_mp #(.bypass_p(0)) u_nob (
      .clk_i(clk), .rst_i(rst), .rf(nif)
   );

   typedef struct {
      logic [1:0]  wv;
      logic [4:0]  wa0;
      logic [4:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic        sv;
      logic [4:0]  sa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        ep0;
      logic        ep1;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] wv,
                        input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic sv, input logic [4:0] sa,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      @(negedge clk);
      bif.wr_v_i        = wv;
      bif.wr_addr_i[0]  = wa0;
      bif.wr_addr_i[1]  = wa1;
      bif.wr_data_i[0]  = wd0;
      bif.wr_data_i[1]  = wd1;
      bif.sb_set_v_i    = sv;
      bif.sb_set_addr_i = sa;
      bif.rd_addr_i[0]  = ra0;
      bif.rd_addr_i[1]  = ra1;
      #1;
   endtask

   task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1);
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, ra0, ra1);
   endtask

   task automatic chk_all_clear(input string nm);
      for (int i = 0; i < 32; i++) begin
         idle_read(5'(i), 5'(31 - i));
         chk({nm, "_d0"}, bif.rd_data_o[0], 32'h0);
         chk({nm, "_d1"}, bif.rd_data_o[1], 32'h0);
         chk({nm, "_p0"}, 32'(bif.rd_pending_o[0]), 32'h0);
         chk({nm, "_p1"}, 32'(bif.rd_pending_o[1]), 32'h0);
      end
   endtask

   initial begin
      vecs[0]  = '{2'b01, 0, 0, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      vecs[2]  = '{2'b11, 5, 6, 'h11, 'h22, 0, 0, 5, 6, 'h11, 'h22, 0, 0};
      vecs[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 5, 6, 'h11, 'h22, 0, 0};
      vecs[4]  = '{2'b11, 7, 7, 'hA, 'hB, 0, 0, 7, 7, 'hB, 'hB, 0, 0};
      vecs[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 7, 5, 'hB, 'h11, 0, 0};
      vecs[6]  = '{2'b00, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 0, 0};
      vecs[7]  = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0};
      vecs[8]  = '{2'b10, 0, 9, 0, 'h55, 0, 0, 9, 9, 'h55, 'h55, 0, 0};
      vecs[9]  = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 5, 'h55, 'h11, 0, 0};
      vecs[10] = '{2'b01, 3, 0, 'h77, 0, 1, 3, 3, 3, 'h77, 'h77, 0, 0};
      vecs[11] = '{2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 'h77, 'h77, 1, 1};
      vecs[12] = '{2'b00, 0, 0, 0, 0, 1, 0, 0, 3, 0, 'h77, 0, 1};
      vecs[13] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 0, 'h77, 0, 1};
      vecs[14] = '{2'b01, 3, 0, 'h78, 0, 0, 0, 3, 0, 'h78, 0, 0, 0};
      vecs[15] = '{2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 'h78, 'h78, 0, 0};
      vecs[16] = '{2'b01, 4, 0, 'h99, 0, 1, 4, 4, 4, 'h99, 'h99, 0, 0};
      vecs[17] = '{2'b10, 0, 10, 0, 'h5, 0, 0, 4, 10, 'h99, 'h5, 1, 0};

      rst = 1'b1;
      idle_read(5'd0, 5'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_all_clear("reset");

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].wv, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0,
               vecs[i].wd1, vecs[i].sv, vecs[i].sa, vecs[i].ra0,
               vecs[i].ra1);
         chk($sformatf("v%0d_d0", i), bif.rd_data_o[0], vecs[i].e0);
         chk($sformatf("v%0d_d1", i), bif.rd_data_o[1], vecs[i].e1);
         chk($sformatf("v%0d_p0", i), 32'(bif.rd_pending_o[0]),
             32'(vecs[i].ep0));
         chk($sformatf("v%0d_p1", i), 32'(bif.rd_pending_o[1]),
             32'(vecs[i].ep1));
      end

      // reset dominates a same-cycle write and scoreboard set
      drive(2'b01, 5'd4, 5'd0, 32'h1, 32'h0, 1'b1, 5'd8, 5'd4, 5'd8);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_read(5'd4, 5'd8);
      chk("mid_rst_r4", bif.rd_data_o[0], 32'h0);
      chk("mid_rst_r8p", 32'(bif.rd_pending_o[1]), 32'h0);
      chk("mid_rst_r4p", 32'(bif.rd_pending_o[0]), 32'h0);
      chk_all_clear("mid_rst");

      // no-bypass: same-cycle write invisible until next cycle
      drive(2'b11, 5'd7, 5'd7, 32'hA, 32'hB, 1'b1, 5'd12, 5'd7, 5'd12);
      chk("nob_same_r7", nif.rd_data_o[0], 32'h0);
      chk("byp_same_r7", bif.rd_data_o[0], 32'hB);
      idle_read(5'd7, 5'd12);
      chk("nob_next_r7", nif.rd_data_o[0], 32'hB);
      chk("nob_pend_r12", 32'(nif.rd_pending_o[1]), 32'h1);
      drive(2'b01, 5'd12, 5'd0, 32'h3C, 32'h0, 1'b0, 5'd0, 5'd12, 5'd12);
      chk("nob_wr_r12_p", 32'(nif.rd_pending_o[0]), 32'h1);
      chk("nob_wr_r12_d", nif.rd_data_o[0], 32'h0);
      chk("byp_wr_r12_p", 32'(bif.rd_pending_o[1]), 32'h0);
      chk("byp_wr_r12_d", bif.rd_data_o[1], 32'h3C);
      idle_read(5'd12, 5'd0);
      chk("nob_after_r12_p", 32'(nif.rd_pending_o[0]), 32'h0);
      chk("nob_after_r12_d", nif.rd_data_o[0], 32'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-ported, parametrised register file: next generation of the core's single-write, two-read register file.
- Supports N read ports, M write ports, optional write-to-read bypass and an optional hard-wired zero register.
- Adds a per-register pending (scoreboard) bit so issue logic can detect RAW hazards on in-flight writes.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- width_p, 32: data width per register.
- els_p, 32: number of registers; power of two, >= 2. Address width lg_els = $clog2(els_p).
- rd_ports_p, 2: number of read ports, >= 1.
- wr_ports_p, 2: number of write ports, >= 1.
- bypass_p, 1: when 1, reads see same-cycle write data; when 0, reads return stored value only.
- zero_reg_p, 1: when 1, register 0 always reads 0, ignores writes and is never pending.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- wr_v_i  in  wr_ports_p  per-port write valid.
- wr_addr_i  in  wr_ports_p x lg_els  per-port write address.
- wr_data_i  in  wr_ports_p x width_p  per-port write data.
- rd_addr_i  in  rd_ports_p x lg_els  per-port read address.
- rd_data_o  out  rd_ports_p x width_p  per-port read data, combinational.
- rd_pending_o  out  rd_ports_p  pending bit of the addressed register, combinational.
- sb_set_v_i  in  1  mark sb_set_addr_i pending (instruction issued with a destination).
- sb_set_addr_i  in  lg_els  register to mark pending.

Behaviour:
- Reset: on a posedge with rst_i=1, all registers are set to 0 and all pending bits are cleared. Writes and scoreboard sets in that cycle are ignored.
- Outputs are combinational. After reset, rd_data_o=0 and rd_pending_o=0 for every address until a write or set occurs.
- Write: on a posedge with wr_v_i[k]=1, store wr_data_i[k] into wr_addr_i[k]. Write latency is 1 cycle to storage, 0 cycles to bypass.
- Write collision: when several valid ports target the same address, the highest-indexed port wins, both for storage and for bypass. There is no error flag.
- Zero register (zero_reg_p=1):
  - Writes to address 0 are discarded.
  - rd_data_o is 0 for address 0 regardless of bypass.
  - sb_set to address 0 is ignored; rd_pending_o for address 0 is always 0.
- Read, bypass_p=1: if any valid write port targets rd_addr_i[j], rd_data_o[j] is that port's data (highest-indexed matching port). Otherwise it is the stored value.
- Read, bypass_p=0: rd_data_o[j] is the stored value; a same-cycle write is not visible until the next cycle.
- Read ports are fully independent; any number of ports may read the same address.
- Scoreboard:
  - A valid write to address a clears pending[a] at the posedge.
  - sb_set_v_i sets pending[sb_set_addr_i] at the posedge.
  - If set and clear hit the same address in one cycle, set wins (the new producer overrides the retiring one), so pending stays 1.
- rd_pending_o[j] = pending[rd_addr_i[j]] & ~(bypass_p & any valid write to rd_addr_i[j] this cycle). With bypass, a same-cycle write resolves the hazard combinationally.
- Writes to non-pending registers are legal and do not change pending state.
- Reset mid-operation: rst_i dominates all writes and sets in that cycle. State after reset is identical to power-on reset.

Test Plan:
- Reset/zero: assert rst_i for 1 cycle, then read addresses 0..31 -> all rd_data_o=0 and rd_pending_o=0. Write 0xDEADBEEF to addr 0 -> still reads 0.
- Basic write/read: port0 writes 0x11 to r5 and port1 writes 0x22 to r6 in one cycle. Next cycle rd0=r5, rd1=r6 -> 0x11, 0x22.
- Collision/bypass (bypass_p=1): both write ports target r7 with 0xA/0xB; same-cycle read of r7 -> 0xB, next-cycle read -> 0xB. With bypass_p=0, the same-cycle read returns the old value 0.
- Scoreboard: sb_set r9, then next cycle read r9 -> pending=1. Write r9 with 0x55 -> same-cycle pending=0 (bypass), next cycle pending=0, data 0x55.
- Set/clear conflict: in one cycle sb_set r3 and write r3 with 0x77. Next cycle -> pending[r3]=1, data 0x77.
- Reset mid-operation: with r4 pending and holding 0x99, assert rst_i together with a write r4=0x1 and sb_set r8 -> next cycle r4=0, no registers pending.
